// File: rtl/rr_arb64_4_pkg.sv
// Shared types and helpers for the rr_arb64_4 round-robin merge point.
//   WIDTH_DEF : default data word width (matches mux64_4_2)
//   NCH_DEF   : channel count (fixed at 4, the mux select is 2 bits)
//   ch_idx_t  : 2-bit channel index
//   state_t   : output stage state, IDLE (empty) / HOLD (full)
//   rr_pick   : round-robin search over the full flags starting at ptr
package rr_arb64_4_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NCH_DEF   = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Returns {found, idx}. Offsets are scanned from the far end back to ptr so
  // the closest full slot (lowest offset from ptr) is the one left standing.
  // With nothing full, idx falls back to ptr.
  function automatic logic [2:0] rr_pick(input logic [3:0] full, input ch_idx_t ptr);
    logic [2:0] res;
    ch_idx_t    idx;
    res = {1'b0, ptr};
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + ch_idx_t'(k);
      if (full[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux64_4_2.sv
// Existing 64-bit 4:1 combinational mux.
//   y0..y3 : data inputs
//   x      : 2-bit select
//   z      : selected word
module mux64_4_2 (
  input  logic [63:0] y0,
  input  logic [63:0] y1,
  input  logic [63:0] y2,
  input  logic [63:0] y3,
  input  logic [1:0]  x,
  output logic [63:0] z
);

  always_comb begin
    case (x)
      2'd0:    z = y0;
      2'd1:    z = y1;
      2'd2:    z = y2;
      default: z = y3;
    endcase
  end

endmodule

// File: rtl/rr_arb64_4.sv
// Round-robin 4-to-1 merge point in front of mux64_4_2. Each input channel
// owns a one-word slot; a round-robin search over the full slots drives the
// mux select, and the mux output is registered into one valid/ready stage.
//   clk, rst             : clock (rising edge), async active-high reset
//   in_valid / in_ready  : per-channel handshake, in_ready[i] = slot i empty
//   in_data0..in_data3   : per-channel words
//   out_valid/out_ready  : output handshake
//   out_data, out_ch     : registered granted word and its source channel
module rr_arb64_4
  import rr_arb64_4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH   = NCH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch
);

  logic [NCH-1:0]   full_q, full_d;
  logic [WIDTH-1:0] slot_q [NCH];
  logic [WIDTH-1:0] in_data [NCH];
  ch_idx_t          ptr_q, ptr_d;
  ch_idx_t          out_ch_q, out_ch_d;
  ch_idx_t          sel;
  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] mux_z;
  logic [NCH-1:0]   fill;
  logic             found;
  logic             grant;

  assign in_data[0] = in_data0;
  assign in_data[1] = in_data1;
  assign in_data[2] = in_data2;
  assign in_data[3] = in_data3;

  // Ready depends only on slot occupancy, never on out_ready.
  assign in_ready = ~full_q;
  assign fill     = in_valid & in_ready;

  always_comb begin
    {found, sel} = rr_pick(full_q, ptr_q);
  end

  // A grant loads the output stage whenever it is empty or being drained.
  assign grant = found & ((state_q == IDLE) | out_ready);

  mux64_4_2 u_mux (
    .y0 (slot_q[0]),
    .y1 (slot_q[1]),
    .y2 (slot_q[2]),
    .y3 (slot_q[3]),
    .x  (sel),
    .z  (mux_z)
  );

  always_comb begin
    full_d      = full_q | fill;
    ptr_d       = ptr_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (grant) begin
      // A granted slot is full, so it cannot be filling on this same edge.
      full_d[sel] = 1'b0;
      out_data_d  = mux_z;
      out_ch_d    = sel;
      ptr_d       = sel + 2'd1;
      out_valid_d = 1'b1;
      state_d     = HOLD;
    end else if ((state_q == HOLD) && out_ready) begin
      // out_data is left as-is; only the valid flag drops.
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q      <= '0;
      ptr_q       <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      full_q      <= full_d;
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  // Slot contents are qualified by full_q, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (fill[i]) slot_q[i] <= in_data[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
